mem_stall_responder: RTL
========================

# mem_stall_responder

Multi-cycle data-memory responder. It serves the processor's memory-stage Rd/Wr requests over a Stall/Done handshake. Requests are 16-bit and word-aligned, and each access takes a fixed, parameterised latency. The block replaces the single-cycle data memory behind the MEM stage, so the pipeline can be exercised against realistic stall behaviour.

## Interface
- `DEPTH_WORDS`, default 256: number of 16-bit words of storage; must be a power of 2.
- `LATENCY`, default 4: number of BUSY cycles per access; must be ≥1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Rd`  in  1  read request; sampled only in IDLE, RESP or ERR.
- `Wr`  in  1  write request; sampled only in IDLE, RESP or ERR.
- `Addr`  in  16  byte address; bit 0 must be 0.
- `DataIn`  in  16  write data; sampled together with the request.
- `DataOut`  out  16  read data; valid only while `Done`=1 for a read.
- `Done`  out  1  one-cycle completion pulse.
- `Stall`  out  1  high while an access is in flight; the processor must hold its request signals.
- `err`  out  1  one-cycle pulse reporting an illegal request.

## Operation
- States: IDLE, BUSY, RESP, ERR. Reset state is IDLE.
- Accepting states are IDLE, RESP and ERR.
- Request decode in an accepting state:
  - `Rd`=`Wr`=0: go to IDLE.
  - `Rd`=`Wr`=1, or `Addr[0]`=1: go to ERR. No storage access occurs.
  - Otherwise: latch op, `Addr`, `DataIn`; load the counter with `LATENCY-1`; go to BUSY.
- BUSY:
  - `Stall`=1.
  - `Rd`/`Wr`/`Addr`/`DataIn` are ignored.
  - The counter decrements each cycle. When the counter is 0, go to RESP.
- Read data and write commit both happen on the BUSY→RESP edge:
  - A read captures `mem[idx]` into the data register.
  - A write commits `mem[idx]`←latched data.
- RESP: `Done`=1. For a read, `DataOut` equals the captured word; otherwise `DataOut`=0.
- ERR: `err`=1, `Done`=0, `Stall`=0.
- Index rule: `idx = Addr[log2(DEPTH_WORDS):1]`. Higher address bits are ignored, so the address space wraps modulo the storage size.
- Outputs in IDLE: `Done`=`err`=`Stall`=0 and `DataOut`=0.
- Storage contents are not reset. The bench must write before reading.

## Timing
- A request sampled at edge E0 produces:
  - `Stall`=1 for exactly `LATENCY` cycles after E0.
  - `Done` (or `err`) in the following cycle, i.e. `LATENCY`+1 cycles after E0.
  - For an illegal request, `err` is high in the cycle right after E0.
- Back-to-back accesses: a request presented during RESP or ERR is accepted at that cycle's edge, with no idle bubble. Sustained throughput is one access per `LATENCY`+1 cycles.
- Read-after-write to the same address, back to back: the read returns the new data, because the write committed before the read was sampled.
- `LATENCY`=1: BUSY lasts one cycle.
- `rst_n` low, at any time and asynchronously:
  - state goes to IDLE;
  - all outputs go to 0 immediately;
  - the counter and data register are cleared;
  - a write that is in BUSY is not committed.
- Release of `rst_n` is synchronous to `clk`. The first request is sampled at the first rising edge with `rst_n`=1.
- `Stall`, `Done` and `err` are decoded from registered state only. There is no combinational path from inputs to outputs.

## Structure
- Package `mem_resp_pkg` contains:
  - the state encoding (IDLE=2'b00, BUSY=2'b01, RESP=2'b10, ERR=2'b11);
  - op constants (OP_RD, OP_WR);
  - a `clog2` helper for the index width.
- Sub-module `mem_word_array`: single-port synchronous 16-bit storage of `DEPTH_WORDS` entries, with write enable, index, write data and a registered read.
- The FSM, request latch and latency counter live in the top module.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release → `Done`=`Stall`=`err`=0 and `DataOut`=16'h0000.
- With `LATENCY`=4: write 16'hBEEF to `Addr` 16'h0010, then read 16'h0010 → `Stall` high for 4 cycles on each access; `Done` in the 5th cycle of each; read `DataOut`=16'hBEEF.
- Back-to-back: write 16'h1234 to 16'h0002, and present a read of 16'h0002 during the write's RESP cycle → the read is accepted with no bubble and returns 16'h1234.
- Illegal requests, each answered by a one-cycle `err` with `Done`=0 and `Stall`=0, storage unchanged:
  - `Rd`=`Wr`=1 at 16'h0004;
  - read of odd `Addr` 16'h0005.
  - A following read of 16'h0004 returns the earlier value.
- Wrap: with `DEPTH_WORDS`=256, write 16'hA5A5 to 16'h0200, then read 16'h0000 → 16'hA5A5.
- Reset mid-write: write 16'h5555 to 16'h0020, which holds 16'h1111, and pull `rst_n` low in the 2nd BUSY cycle → outputs go to 0 immediately; a later read of 16'h0020 returns 16'h1111.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
//   state_e : FSM encoding (IDLE/BUSY/RESP/ERR)
//   OP_RD/OP_WR : latched operation codes
//   req_t   : request latched on acceptance (op, byte address, write data)
//   clog2   : ceil(log2(v)), used for index and counter widths
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef struct packed {
    logic        op;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port synchronous 16-bit word storage.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we, re     : write enable, read enable (mutually exclusive by use)
//   idx        : word index
//   wdata      : write data
//   rdata      : registered read data, updated on the edge where re=1
// Storage contents are deliberately not reset.
module mem_word_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata
);

  logic [15:0] mem [DEPTH_WORDS];
  logic [15:0] rdata_d, rdata_q;

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[idx];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_stall_responder.sv
// Multi-cycle data-memory responder behind the MEM stage.
//   clk, rst_n      : clock, async active-low reset
//   Rd, Wr, Addr    : request, sampled in IDLE/RESP/ERR only
//   DataIn          : write data, sampled with the request
//   DataOut         : read data, nonzero only in RESP of a read
//   Done            : one-cycle completion pulse (RESP)
//   Stall           : high while an access is in flight (BUSY)
//   err             : one-cycle illegal-request pulse (ERR)
// Every access spends LATENCY cycles in BUSY; storage is touched only on the
// BUSY->RESP edge, so a back-to-back read sees a preceding write.
module mem_stall_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err
);

  localparam int IDX_W = clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? clog2(LATENCY) : 1;

  state_e            state_d, state_q;
  req_t              req_d, req_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              accepting, accept, fin, mem_we, mem_re;
  logic [15:0]       rdata;
  logic              unused_addr;

  // Upper address bits wrap; only the index slice reaches storage.
  assign unused_addr = ^req_q.addr;

  assign accepting = (state_q != ST_BUSY);
  assign fin       = (state_q == ST_BUSY) && (cnt_q == '0);
  assign mem_we    = fin && (req_q.op == OP_WR);
  assign mem_re    = fin && (req_q.op == OP_RD);

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BUSY: if (cnt_q == '0) state_d = ST_RESP;
      default: begin
        if (!Rd && !Wr)              state_d = ST_IDLE;
        else if ((Rd && Wr) || Addr[0]) state_d = ST_ERR;
        else                         state_d = ST_BUSY;
      end
    endcase
  end

  assign accept = accepting && (state_d == ST_BUSY);

  // Request latch and latency counter
  always_comb begin
    req_d = req_q;
    cnt_d = cnt_q;
    if (accept) begin
      req_d = '{op: (Wr ? OP_WR : OP_RD), addr: Addr, data: DataIn};
      cnt_d = CNT_W'(LATENCY - 1);
    end else if (state_q == ST_BUSY && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req_q <= '0;
      cnt_q <= '0;
    end else begin
      req_q <= req_d;
      cnt_q <= cnt_d;
    end

  mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (req_q.addr[IDX_W:1]),
    .wdata (req_q.data),
    .rdata (rdata)
  );

  // Outputs decoded from registered state only
  always_comb begin
    Stall   = (state_q == ST_BUSY);
    Done    = (state_q == ST_RESP);
    err     = (state_q == ST_ERR);
    DataOut = '0;
    if (state_q == ST_RESP && req_q.op == OP_RD) DataOut = rdata;
  end

endmodule
